// File: rtl/nco_hop_sched.sv
// nco_hop_sched: queues {inc, dwell} hops and applies them to the NCO on
// symbol boundaries; optional NCO_HOP_LOOPCLR_EN clears freq_mod_o on hops.
module nco_hop_sched #(
  parameter int APR     = 31,
  parameter int APRF    = 31,
  parameter int DEPTH   = 4,
  parameter int DW      = 16,
  parameter int NCO_LAT = 12,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1,
  localparam int SW     = $clog2(NCO_LAT + 1) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clken,
  input  logic            sym_stb,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [APR-1:0]  wr_inc,
  input  logic [DW-1:0]   wr_dwell,
  input  logic            flush,
  input  logic            mod_valid,
  input  logic [APRF-1:0] mod_in,
  input  logic            underrun_clr,
  output logic [APR-1:0]  phi_inc_o,
  output logic [APRF-1:0] freq_mod_o,
  output logic            hop_o,
  output logic            settled_o,
  output logic            underrun_o,
  output logic [LW-1:0]   level_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [APR-1:0]  phi_q, phi_d;
  logic [APRF-1:0] fmod_q, fmod_d;
  logic            hop_q, hop_d;
  logic            unr_q, unr_d;

  logic [APR-1:0]  mem_inc_q [DEPTH];
  logic [DW-1:0]   mem_dw_q  [DEPTH];

  logic            wr_en;
  logic            nonempty;
  logic            hop;
  logic            stall;
  logic [APR-1:0]  head_inc;
  logic [DW-1:0]   head_dw;

  // hop/stall decision and next-state computation
  always_comb begin
    wr_ready = count_q < LW'(DEPTH);
    wr_en    = clken & wr_valid & wr_ready & ~flush;
    nonempty = count_q != '0;
    head_inc = mem_inc_q[rptr_q];
    head_dw  = mem_dw_q[rptr_q];
    hop      = 1'b0;
    stall    = 1'b0;
    if (clken && !flush) begin
      unique case (state_q)
        S_IDLE:  hop = nonempty;
        S_DWELL: begin
          if (sym_stb && dcnt_q == DW'(1)) begin
            hop   = nonempty;
            stall = ~nonempty;
          end
        end
        S_STALL: hop = sym_stb & nonempty;
        default: ;
      endcase
    end

    state_d = state_q;
    if (clken) begin
      if (flush)      state_d = S_IDLE;
      else if (hop)   state_d = S_DWELL;
      else if (stall) state_d = S_STALL;
    end

    dcnt_d = dcnt_q;
    if (hop)
      dcnt_d = (head_dw == '0) ? DW'(1) : head_dw;
    else if (clken && !flush && state_q == S_DWELL
             && sym_stb && dcnt_q != '0)
      dcnt_d = dcnt_q - DW'(1);

    if (flush && clken) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      count_d = count_q + LW'(wr_en) - LW'(hop);
      wptr_d  = wptr_q + AW'(wr_en);
      rptr_d  = rptr_q + AW'(hop);
    end

    scnt_d = scnt_q;
    if (hop)
      scnt_d = SW'(NCO_LAT);
    else if (clken && scnt_q != '0)
      scnt_d = scnt_q - SW'(1);

    phi_d = hop ? head_inc : phi_q;

    fmod_d = fmod_q;
    if (clken && !flush && mod_valid)
      fmod_d = mod_in;
`ifdef NCO_HOP_LOOPCLR_EN
    if (hop)
      fmod_d = '0;
`endif

    hop_d = hop;

    unr_d = unr_q;
    if (clken && underrun_clr) unr_d = 1'b0;
    if (stall)                 unr_d = 1'b1;
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      phi_q   <= '0;
      fmod_q  <= '0;
      hop_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      phi_q   <= phi_d;
      fmod_q  <= fmod_d;
      hop_q   <= hop_d;
      unr_q   <= unr_d;
    end
  end

  // hop queue storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_inc_q[wptr_q] <= wr_inc;
      mem_dw_q[wptr_q]  <= wr_dwell;
    end
  end

  assign phi_inc_o  = phi_q;
  assign freq_mod_o = fmod_q;
  assign hop_o      = hop_q;
  assign underrun_o = unr_q;
  assign level_o    = count_q;
  assign settled_o  = (scnt_q == '0) && (state_q != S_IDLE);

endmodule

// File: tb/tb_nco_hop_sched.sv
// tb_nco_hop_sched: scoreboard bench for nco_hop_sched.
// Expected hop increments are queued on write and checked on hop_o.
module tb_nco_hop_sched;

  logic        clk = 1'b0;
  logic        reset, clken, sym_stb, wr_valid, wr_ready;
  logic [30:0] wr_inc;
  logic [15:0] wr_dwell;
  logic        flush, mod_valid, underrun_clr;
  logic [30:0] mod_in;
  logic [30:0] phi_inc_o, freq_mod_o;
  logic        hop_o, settled_o, underrun_o;
  logic [2:0]  level_o;

  int n_vec = 0;
  int n_err = 0;
  logic [30:0] exp_q [$];

  nco_hop_sched dut (
    .clk(clk), .reset(reset), .clken(clken), .sym_stb(sym_stb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_inc(wr_inc),
    .wr_dwell(wr_dwell), .flush(flush), .mod_valid(mod_valid),
    .mod_in(mod_in), .underrun_clr(underrun_clr),
    .phi_inc_o(phi_inc_o), .freq_mod_o(freq_mod_o), .hop_o(hop_o),
    .settled_o(settled_o), .underrun_o(underrun_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phi"}, 64'(phi_inc_o), 64'h0);
    chk({tag, "_fmod"}, 64'(freq_mod_o), 64'h0);
    chk({tag, "_hop"}, 64'(hop_o), 64'h0);
    chk({tag, "_settled"}, 64'(settled_o), 64'h0);
    chk({tag, "_unr"}, 64'(underrun_o), 64'h0);
    chk({tag, "_level"}, 64'(level_o), 64'h0);
    chk({tag, "_ready"}, 64'(wr_ready), 64'h1);
  endtask

  // scoreboard: every hop must apply the oldest expected increment
  always @(negedge clk) begin
    if (hop_o) begin
      if (exp_q.size() == 0)
        chk("hop_unexpected", 64'(phi_inc_o), 64'h7fff_ffff_ffff);
      else
        chk("hop_inc", 64'(phi_inc_o), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_hop;
    logic [5:0] exp_unr;
    logic [30:0] fm_exp;
    reset = 1'b1; clken = 1'b1; sym_stb = 1'b0;
    wr_valid = 1'b0; wr_inc = '0; wr_dwell = '0;
    flush = 1'b0; mod_valid = 1'b0; mod_in = '0;
    underrun_clr = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // basic hop
    wr_valid = 1'b1; wr_inc = 31'h1000_0000; wr_dwell = 16'd2;
    exp_q.push_back(31'h1000_0000);
    tick();
    wr_valid = 1'b0;
    chk("basic_level", 64'(level_o), 64'd1);
    chk("basic_nohop", 64'(hop_o), 64'd0);
    tick();
    chk("basic_hop", 64'(hop_o), 64'd1);
    chk("basic_phi", 64'(phi_inc_o), 64'h1000_0000);
    chk("basic_settle0", 64'(settled_o), 64'd0);
    chk("basic_level0", 64'(level_o), 64'd0);
    repeat (11) tick();
    chk("basic_settle11", 64'(settled_o), 64'd0);
    tick();
    chk("basic_settle12", 64'(settled_o), 64'd1);
    chk("basic_hop_low", 64'(hop_o), 64'd0);

    // sequential hops, dwells 1,3,2
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_inc = 31'h100 * 31'(i + 1);
      wr_dwell = (i == 0) ? 16'd1 : (i == 1) ? 16'd3 : 16'd2;
      exp_q.push_back(wr_inc);
      tick();
    end
    wr_valid = 1'b0;
    chk("seq_level", 64'(level_o), 64'd2);
    chk("seq_phi_first", 64'(phi_inc_o), 64'h100);
    exp_hop = 6'b001001;
    exp_unr = 6'b100000;
    for (int s = 0; s < 6; s++) begin
      repeat (7) tick();
      sym_stb = 1'b1;
      tick();
      sym_stb = 1'b0;
      chk($sformatf("seq_hop_s%0d", s + 1), 64'(hop_o), 64'(exp_hop[s]));
      chk($sformatf("seq_unr_s%0d", s + 1), 64'(underrun_o),
          64'(exp_unr[s]));
    end
    chk("seq_level_end", 64'(level_o), 64'd0);
    chk("seq_phi_end", 64'(phi_inc_o), 64'h300);
    chk("seq_settled", 64'(settled_o), 64'd1);

    // stall waits for a strobe
    wr_valid = 1'b1; wr_inc = 31'h400; wr_dwell = 16'd5;
    exp_q.push_back(31'h400);
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    chk("stall_nohop", 64'(hop_o), 64'd0);
    chk("stall_level", 64'(level_o), 64'd1);
    sym_stb = 1'b1;
    tick();
    sym_stb = 1'b0;
    chk("stall_hop", 64'(hop_o), 64'd1);
    chk("stall_level0", 64'(level_o), 64'd0);
    chk("stall_settle0", 64'(settled_o), 64'd0);
    chk("stall_unr_sticky", 64'(underrun_o), 64'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("unr_clr", 64'(underrun_o), 64'd0);

    // full queue
    do_reset();
    wr_valid = 1'b1; wr_inc = 31'h500; wr_dwell = 16'd1;
    exp_q.push_back(31'h500);
    tick();
    wr_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1; wr_inc = 31'h600 + 31'(k); wr_dwell = 16'd1;
      if (k < 4) exp_q.push_back(wr_inc);
      tick();
      chk($sformatf("full_level_w%0d", k + 1), 64'(level_o),
          64'((k < 4) ? k + 1 : 4));
      chk($sformatf("full_ready_w%0d", k + 1), 64'(wr_ready),
          64'((k < 3) ? 1 : 0));
    end
    wr_inc = 31'h700;
    sym_stb = 1'b1;
    tick();
    sym_stb = 1'b0;
    wr_valid = 1'b0;
    chk("full_pop_hop", 64'(hop_o), 64'd1);
    chk("full_pop_level", 64'(level_o), 64'd3);
    chk("full_pop_ready", 64'(wr_ready), 64'd1);
    wr_valid = 1'b1; wr_inc = 31'h710; wr_dwell = 16'd1;
    exp_q.push_back(31'h710);
    sym_stb = 1'b1;
    tick();
    wr_valid = 1'b0;
    sym_stb = 1'b0;
    chk("wrpop_hop", 64'(hop_o), 64'd1);
    chk("wrpop_level", 64'(level_o), 64'd3);

    // loop correction
    do_reset();
    mod_valid = 1'b1; mod_in = 31'h55;
    tick();
    mod_valid = 1'b0;
    chk("mod_lat", 64'(freq_mod_o), 64'h55);
    tick();
    chk("mod_hold", 64'(freq_mod_o), 64'h55);
    wr_valid = 1'b1; wr_inc = 31'h800; wr_dwell = 16'd3;
    exp_q.push_back(31'h800);
    tick();
    wr_valid = 1'b0;
    mod_valid = 1'b1; mod_in = 31'h100;
    tick();
    mod_valid = 1'b0;
`ifdef NCO_HOP_LOOPCLR_EN
    fm_exp = 31'h0;
`else
    fm_exp = 31'h100;
`endif
    chk("mod_hop_hop", 64'(hop_o), 64'd1);
    chk("mod_hop_fmod", 64'(freq_mod_o), 64'(fm_exp));

    // flush mid-dwell
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1; wr_inc = 31'h900 + 31'(k); wr_dwell = 16'd1;
      tick();
    end
    wr_valid = 1'b0;
    chk("flush_pre_level", 64'(level_o), 64'd2);
    repeat (12) tick();
    chk("flush_pre_settled", 64'(settled_o), 64'd1);
    flush = 1'b1;
    wr_valid = 1'b1; wr_inc = 31'hA00; wr_dwell = 16'd1;
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    chk("flush_level", 64'(level_o), 64'd0);
    chk("flush_settled", 64'(settled_o), 64'd0);
    chk("flush_phi", 64'(phi_inc_o), 64'h800);
    chk("flush_fmod", 64'(freq_mod_o), 64'(fm_exp));
    tick();
    tick();
    chk("flush_drop_level", 64'(level_o), 64'd0);
    chk("flush_drop_hop", 64'(hop_o), 64'd0);
    wr_valid = 1'b1; wr_inc = 31'hB00; wr_dwell = 16'd2;
    exp_q.push_back(31'hB00);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("flush_idle_hop", 64'(hop_o), 64'd1);
    chk("flush_idle_phi", 64'(phi_inc_o), 64'hB00);

    // reset mid-settle
    repeat (6) tick();
    wr_valid = 1'b1; wr_inc = 31'hC00; wr_dwell = 16'd1;
    tick();
    wr_valid = 1'b0;
    chk("midrst_level_pre", 64'(level_o), 64'd1);
    chk("midrst_settle_pre", 64'(settled_o), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk_reset_vals("midrst");
    tick();
    tick();
    chk("midrst_nohop", 64'(hop_o), 64'd0);
    chk("midrst_level", 64'(level_o), 64'd0);

    // clken stretching
    clken = 1'b0;
    wr_valid = 1'b1; wr_inc = 31'hD00; wr_dwell = 16'd1;
    tick();
    tick();
    chk("clken_nowrite", 64'(level_o), 64'd0);
    clken = 1'b1;
    exp_q.push_back(31'hD00);
    tick();
    wr_valid = 1'b0;
    chk("clken_write", 64'(level_o), 64'd1);
    clken = 1'b0;
    tick();
    tick();
    chk("clken_nohop", 64'(hop_o), 64'd0);
    chk("clken_level_hold", 64'(level_o), 64'd1);
    clken = 1'b1;
    tick();
    chk("clken_hop", 64'(hop_o), 64'd1);
    chk("clken_phi", 64'(phi_inc_o), 64'hD00);
    clken = 1'b0;
    tick();
    chk("clken_hop_low", 64'(hop_o), 64'd0);
    for (int i = 0; i < 12; i++) begin
      clken = 1'b1;
      tick();
      clken = 1'b0;
      tick();
      if (i == 10) chk("clken_settle11", 64'(settled_o), 64'd0);
    end
    chk("clken_settle12", 64'(settled_o), 64'd1);
    clken = 1'b1;
    tick();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
